// File: rtl/sram_ctrl_if.sv
// Pipeline-side and SRAM-pin signals of the data-memory controller, bundled
// so the controller and its environment connect through one port.
interface sram_ctrl_if #(
    parameter int SRAM_ADDR_WIDTH = 18
);
    logic                       rd_en;
    logic                       wr_en;
    logic [31:0]                address;
    logic [31:0]                write_data;
    logic [31:0]                read_data;
    logic                       ready;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic                       sram_we_n;
    logic [15:0]                sram_dq_out;
    logic                       sram_dq_oe;
    logic [15:0]                sram_dq_in;

    // Environment side: the pipeline registers plus the SRAM chip.
    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );
endinterface

// File: rtl/sram_ctrl.sv
// Sequences each 32-bit load/store as two 16-bit SRAM phases (low half, then
// high half) and holds ready low so the pipeline freezes until the access ends.
module sram_ctrl #(
    parameter int ADDR_BASE       = 1024,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 2
) (
    input logic         clk,
    input logic         rst,
    sram_ctrl_if.slave  bus
);
    localparam int         WORD_W = SRAM_ADDR_WIDTH - 1;
    localparam logic [3:0] LAST   = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

    state_t            state;
    state_t            state_next;
    op_t               op;
    logic [3:0]        count;
    logic [WORD_W-1:0] word;
    logic [31:0]       wdata;
    logic [31:0]       read_data;
    logic              req;
    logic              last;

    assign req           = bus.rd_en | bus.wr_en;
    assign last          = (count == LAST);
    assign bus.read_data = read_data;

    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            op        <= OP_READ;
            word      <= '0;
            wdata     <= '0;
            read_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (req) begin
                        op    <= bus.wr_en ? OP_WRITE : OP_READ;
                        wdata <= bus.write_data;
                        // Word index wraps modulo the SRAM size; low addresses wrap too.
                        word  <= WORD_W'((bus.address - 32'(ADDR_BASE)) >> 2);
                    end
                end
                LOW, HIGH: begin
                    count <= last ? '0 : count + 4'd1;
                    if (last && op == OP_READ) begin
                        if (state == LOW) read_data[15:0]  <= bus.sram_dq_in;
                        else              read_data[31:16] <= bus.sram_dq_in;
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        state_next      = state;
        bus.ready       = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_we_n   = 1'b1;
        bus.sram_dq_out = 16'h0000;
        bus.sram_dq_oe  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = ~req;
                if (req) state_next = LOW;
            end
            LOW: begin
                bus.sram_addr  = {word, 1'b0};
                bus.sram_we_n  = (op != OP_WRITE);
                bus.sram_dq_oe = (op == OP_WRITE);
                if (op == OP_WRITE) bus.sram_dq_out = wdata[15:0];
                if (last) state_next = HIGH;
            end
            HIGH: begin
                bus.sram_addr  = {word, 1'b1};
                bus.sram_we_n  = (op != OP_WRITE);
                bus.sram_dq_oe = (op == OP_WRITE);
                if (op == OP_WRITE) bus.sram_dq_out = wdata[31:16];
                if (last) state_next = DONE;
            end
            DONE: begin
                bus.ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Multi-cycle controller for the off-chip 16-bit SRAM used as the pipeline's data memory. It sits between the execute/memory pipeline registers and the SRAM pins. It takes the 32-bit ALU result as the address, the forwarded Rm value as the store data, and the memory read/write enables. Each 32-bit access is sequenced as two 16-bit half-word phases, and `ready` is held low so the hazard/freeze logic stalls every earlier stage until the access completes.

## Interface
Parameters:
- `ADDR_BASE`, 1024, byte address mapped to SRAM word 0; subtracted from `address`.
- `SRAM_ADDR_WIDTH`, 18, SRAM half-word address width.
- `WAIT_CYCLES`, 2, clock cycles per half-word phase; legal range 1..15.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in 1: load request (mem_read from the execute stage).
- `wr_en` in 1: store request (mem_write from the execute stage).
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data (forwarded Rm value).
- `read_data` out 32: load result, held until the next read completes.
- `ready` out 1: high when no access is pending; low means freeze the pipeline.
- `sram_addr` out SRAM_ADDR_WIDTH: SRAM half-word address.
- `sram_we_n` out 1: SRAM write enable, active low.
- `sram_dq_out` out 16: data driven toward the SRAM.
- `sram_dq_oe` out 1: tristate enable for `sram_dq_out`; the top level builds the inout.
- `sram_dq_in` in 16: data returned from the SRAM.

## Operation
- States are IDLE, LOW, HIGH and DONE. A phase counter counts 0..WAIT_CYCLES-1.
- IDLE → LOW when `rd_en|wr_en` is high.
  - On that edge, latch `op` (write if `wr_en`, else read), `wdata` = `write_data` and `word` = (`address` − ADDR_BASE) >> 2.
  - `wr_en` has priority when both enables are high.
- LOW → HIGH when counter = WAIT_CYCLES-1; the counter clears on the transition.
- HIGH → DONE when counter = WAIT_CYCLES-1.
- DONE → IDLE unconditionally after one cycle. A request present in that IDLE cycle starts a new access.
- Address mapping:
  - In LOW, `sram_addr` = {word,1'b0}; in HIGH, `sram_addr` = {word,1'b1}.
  - Both are truncated to SRAM_ADDR_WIDTH, so the address wraps modulo 2^SRAM_ADDR_WIDTH half-words.
  - Subtraction is 32-bit unsigned. Addresses below ADDR_BASE wrap and are not flagged.
- Write:
  - `sram_dq_oe`=1 and `sram_we_n`=0 for every cycle of LOW and HIGH.
  - `sram_dq_out` = wdata[15:0] in LOW and wdata[31:16] in HIGH.
- Read:
  - `sram_we_n`=1 and `sram_dq_oe`=0.
  - `sram_dq_in` is sampled on the final cycle of LOW into read_data[15:0], and on the final cycle of HIGH into read_data[31:16].
- `ready` is combinational:
  - In IDLE, `ready` = ~(rd_en|wr_en).
  - In LOW and HIGH, `ready` = 0.
  - In DONE, `ready` = 1.
- In IDLE and DONE: `sram_addr`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_dq_out`=0.
- Reset (any state, including mid-access):
  - Go to IDLE and clear the counter, latched op/word/wdata and `read_data` (=0).
  - `sram_we_n` goes to 1 in the cycle after the reset edge. An in-progress write is abandoned, and a half-written word is acceptable.

## Timing
- Reset values: state IDLE, `read_data`=0, `sram_addr`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_dq_out`=0, `ready`=~(rd_en|wr_en).
- Latency:
  - A request first seen in IDLE gives `ready`=0 for 1+2·WAIT_CYCLES cycles (5 for the default).
  - `ready`=1 in the DONE cycle, and the pipeline advances on that edge.
- Load data: `read_data` holds the full word from the start of DONE onward.
- Input stability: request inputs are stable throughout the access because the pipeline is frozen. They are only sampled on the IDLE→LOW edge.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE. That IDLE cycle shows `ready`=0 if a request is present, giving 2+2·WAIT_CYCLES cycles per access.
- Parameter edge case: WAIT_CYCLES=1 gives one cycle per phase and 3 stall cycles.

## Test plan
- **Store.** Reset, then `wr_en`=1, `address`=1032, `write_data`=0xDEADBEEF.
  - Expect `sram_addr`=4 with `sram_dq_out`=0xBEEF for 2 cycles, then `sram_addr`=5 with 0xDEAD for 2 cycles.
  - `sram_we_n`=0 for exactly 4 cycles; `ready` low for 5 cycles, then high for 1 cycle.
- **Load.** `rd_en`=1, `address`=1032, with an SRAM model holding the previous store.
  - Expect `read_data`=0xDEADBEEF from the DONE cycle onward, `sram_we_n`=1 throughout and `sram_dq_oe`=0.
- **Back-to-back.** Store 0x12345678 to 1024, then immediately load 1024.
  - Expect the second access to start in the IDLE cycle after DONE, and `read_data`=0x12345678.
- **Wrap and priority.**
  - `address`=1024+0x80000 with `rd_en` and `wr_en` both high: expect a write at `sram_addr` 0 then 1.
  - `address`=1020: expect `sram_addr` 0x3FFFE then 0x3FFFF.
- **Reset mid-write.** Assert `rst` during the HIGH phase.
  - Next cycle: IDLE, `sram_we_n`=1, `read_data`=0, `ready`=1 with no request present.
  - A subsequent load of the same word returns the new low half and the old high half.
- **WAIT_CYCLES=1 build.** Store then load 0xA5A55A5A.
  - Expect each access to stall 3 cycles and the data to round-trip.
